// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the multicycle subtractor, the carry-select adder
// and the status register.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic bout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/borrow_select_subtractor_seq_if.sv
// Handshake and operand/result bundle between the multicycle control unit
// and the subtractor.
interface borrow_select_subtractor_seq_if #(
    parameter int WIDTH = alu_pkg::WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );

endinterface

// File: rtl/ripple_borrow_sub4.sv
// Combinational ripple-borrow subtractor: diff = a - b - bin, with borrow-out.
module ripple_borrow_sub4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] borrow;

    assign borrow[0] = bin;

    // A bit borrows when it is 0-1, or when it is equal and a borrow arrives.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[W];

endmodule

// File: rtl/borrow_select_subtractor_seq.sv
// Multicycle signed subtractor: one borrow-select slice per clock, LSB first,
// under a start/busy/done handshake.
module borrow_select_subtractor_seq #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SLICE = alu_pkg::SLICE
) (
    input  logic                           clk,
    input  logic                           rst,
    borrow_select_subtractor_seq_if.slave  bus
);

    import alu_pkg::*;

    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int MSB     = WIDTH - 1;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow_r;
    logic [WIDTH-1:0] diff_r;
    flags_t           flags;
    logic             busy_r;
    logic             done_r;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] diff0;
    logic [SLICE-1:0] diff1;
    logic             bout0;
    logic             bout1;
    logic [SLICE-1:0] sel_diff;
    logic             sel_bout;
    logic [WIDTH-1:0] diff_next;
    logic             last;
    logic             accept;

    assign a_s = a_r[idx*SLICE +: SLICE];
    assign b_s = b_r[idx*SLICE +: SLICE];

    ripple_borrow_sub4 #(.W(SLICE)) u_sub_b0 (
        .a    (a_s),
        .b    (b_s),
        .bin  (1'b0),
        .diff (diff0),
        .bout (bout0)
    );

    ripple_borrow_sub4 #(.W(SLICE)) u_sub_b1 (
        .a    (a_s),
        .b    (b_s),
        .bin  (1'b1),
        .diff (diff1),
        .bout (bout1)
    );

    assign sel_diff = borrow_r ? diff1 : diff0;
    assign sel_bout = borrow_r ? bout1 : bout0;
    assign last     = (idx == IDXW'(NSLICES - 1));
    assign accept   = bus.start && ((state == IDLE) || (state == DONE));

    // The full result including the slice being finished, so flags see the final value.
    always_comb begin
        diff_next = diff_r;
        diff_next[idx*SLICE +: SLICE] = sel_diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            borrow_r <= 1'b0;
            diff_r   <= '0;
            flags    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (accept) begin
            state    <= RUN;
            idx      <= '0;
            a_r      <= bus.a;
            b_r      <= bus.b;
            borrow_r <= bus.bin;
            diff_r   <= '0;
            flags    <= '0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    diff_r   <= diff_next;
                    borrow_r <= sel_bout;
                    if (last) begin
                        flags.bout <= sel_bout;
                        flags.ovf  <= (a_r[MSB] != b_r[MSB]) && (diff_next[MSB] != a_r[MSB]);
                        flags.zero <= (diff_next == '0);
                        idx        <= '0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = flags.bout;
    assign bus.ovf  = flags.ovf;
    assign bus.zero = flags.zero;

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Scoreboard bench for the multicycle borrow-select subtractor: expected results
// come from an arithmetic reference model and are popped on each done pulse.
module tb_borrow_select_subtractor_seq;

    import alu_pkg::*;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    borrow_select_subtractor_seq_if #(.WIDTH(16)) bus ();

    borrow_select_subtractor_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic exp_t model(input logic [15:0] a_in, input logic [15:0] b_in, input logic bin_in);
        exp_t        e;
        longint      ua;
        longint      ub;
        longint      full;
        longint      sx;
        logic [15:0] low;
        ua     = longint'(a_in);
        ub     = longint'(b_in);
        full   = ua - ub - longint'(bin_in);
        low    = full[15:0];
        e.diff = low;
        e.bout = (ua < ub + longint'(bin_in));
        sx     = longint'($signed(a_in)) - longint'($signed(b_in)) - longint'(bin_in);
        e.ovf  = (sx > 32767) || (sx < -32768);
        e.zero = (low == 16'h0000);
        return e;
    endfunction

    task automatic issue(input logic [15:0] a_in, input logic [15:0] b_in, input logic bin_in);
        bus.a     = a_in;
        bus.b     = b_in;
        bus.bin   = bin_in;
        bus.start = 1'b1;
        sb_q.push_back(model(a_in, b_in, bin_in));
    endtask

    // Steps the clock until done (bounded); optionally pokes start mid-run.
    task automatic run_until_done(input int inject_cycle, output int cycles, output int busy_cnt,
                                  output bit seen, output logic [15:0] diff_c1, output logic [2:0] flags_c1);
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        diff_c1  = 'x;
        flags_c1 = 'x;
        while (!seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                bus.start = 1'b0;
                diff_c1   = bus.diff;
                flags_c1  = {bus.bout, bus.ovf, bus.zero};
            end
            if (inject_cycle != 0 && cycles == inject_cycle) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
                bus.b     = 16'h1111;
                bus.bin   = 1'b1;
            end
            if (inject_cycle != 0 && cycles == inject_cycle + 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
        checks++;
        if (bus.diff !== 16'h0000) begin errors++; $display("[TB] FAIL reset_diff got=%h want=0000", bus.diff); end
        checks++;
        if ({bus.bout, bus.ovf, bus.zero} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b want=000", {bus.bout, bus.ovf, bus.zero});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        logic [15:0] va[6] = '{16'h0005, 16'h1000, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234};
        logic [15:0] vb[6] = '{16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h1233};
        logic        vc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          cycles;
        int          busy_cnt;
        bit          seen;
        logic [15:0] diff_c1;
        logic [2:0]  flags_c1;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vc[i]);
            run_until_done(0, cycles, busy_cnt, seen, diff_c1, flags_c1);
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL vec%0d_timeout got=no_done want=done", i);
                sb_q.delete();
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (cycles != 5 || busy_cnt != 4) begin
                errors++;
                $display("[TB] FAIL vec%0d_latency got=done@%0d busy=%0d want=done@5 busy=4", i, cycles, busy_cnt);
            end
            checks++;
            if (diff_c1 !== 16'h0000 || flags_c1 !== 3'b000) begin
                errors++;
                $display("[TB] FAIL vec%0d_clear got=%h/%b want=0000/000", i, diff_c1, flags_c1);
            end
            checks++;
            if (bus.diff !== e.diff) begin
                errors++;
                $display("[TB] FAIL vec%0d_diff got=%h want=%h", i, bus.diff, e.diff);
            end
            checks++;
            if ({bus.bout, bus.ovf, bus.zero} !== {e.bout, e.ovf, e.zero}) begin
                errors++;
                $display("[TB] FAIL vec%0d_flags got=%b want=%b", i, {bus.bout, bus.ovf, bus.zero}, {e.bout, e.ovf, e.zero});
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.diff !== e.diff) begin
                errors++;
                $display("[TB] FAIL vec%0d_hold got=done%b/%h want=done0/%h", i, bus.done, bus.diff, e.diff);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cycles;
        int          busy_cnt;
        bit          seen;
        logic [15:0] diff_c1;
        logic [2:0]  flags_c1;
        exp_t        e;
        issue(16'h0100, 16'h0001, 1'b0);
        run_until_done(2, cycles, busy_cnt, seen, diff_c1, flags_c1);
        checks++;
        if (!seen || cycles != 5) begin
            errors++;
            $display("[TB] FAIL ignore_start_timing got=seen%0d@%0d want=seen1@5", seen, cycles);
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.diff !== e.diff) begin
            errors++;
            $display("[TB] FAIL ignore_start_diff got=%h want=%h", bus.diff, e.diff);
        end
        issue(16'h0010, 16'h0001, 1'b0);
        run_until_done(0, cycles, busy_cnt, seen, diff_c1, flags_c1);
        checks++;
        if (!seen || cycles != 5) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got=seen%0d@%0d want=seen1@5", seen, cycles);
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.diff !== e.diff || {bus.bout, bus.ovf, bus.zero} !== {e.bout, e.ovf, e.zero}) begin
            errors++;
            $display("[TB] FAIL b2b_result got=%h/%b want=%h/%b", bus.diff, {bus.bout, bus.ovf, bus.zero},
                     e.diff, {e.bout, e.ovf, e.zero});
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int done_cnt = 0;
        issue(16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl got=busy%b done%b want=busy0 done0", bus.busy, bus.done);
        end
        checks++;
        if (bus.diff !== 16'h0000 || {bus.bout, bus.ovf, bus.zero} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midrst_data got=%h/%b want=0000/000", bus.diff, {bus.bout, bus.ovf, bus.zero});
        end
        rst = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("[TB] FAIL midrst_quiet got=%0d active cycles want=0", done_cnt);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
